// File: rtl/mem_io_bridge_pkg.sv
// Shared constants and helpers for the CPU memory/I-O bridge.
// The I/O window and port numbers live here so decode and software headers agree.
package mem_io_bridge_pkg;
    localparam int BYTE_W = 8;
    localparam int CPU_AW = 32;
    localparam int CNT_W  = 32;

    localparam logic [1:0] IO_SEL_BITS  = 2'b11;
    localparam logic [2:0] IO_PORT_UART = 3'd0;
    localparam logic [2:0] IO_PORT_CLK  = 3'd4;

    typedef logic [BYTE_W-1:0] byte_t;

    // Little-endian byte select out of a counter word.
    function automatic byte_t cnt_byte(input logic [CNT_W-1:0] value, input logic [1:0] idx);
        return byte_t'(value >> {idx, 3'b000});
    endfunction
endpackage

// File: rtl/mem_io_bridge_if.sv
// CPU-side byte bus between the cpu top (master) and the memory/I-O bridge (slave).
interface mem_io_bridge_if;
    import mem_io_bridge_pkg::*;

    logic [CPU_AW-1:0] cpu_a;
    byte_t             cpu_dout;
    logic              cpu_wr;
    byte_t             cpu_din;
    logic              io_buffer_full;

    modport master (output cpu_a, cpu_dout, cpu_wr, input  cpu_din, io_buffer_full);
    modport slave  (input  cpu_a, cpu_dout, cpu_wr, output cpu_din, io_buffer_full);
endinterface

// File: rtl/mem_io_bridge_byte_fifo.sv
// Byte FIFO with occupancy count; a push on a full FIFO succeeds only alongside a pop.
module mem_io_bridge_byte_fifo
    import mem_io_bridge_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  byte_t                  push_data,
    input  logic                   pop,
    output byte_t                  data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    byte_t          mem [DEPTH];
    logic [PW-1:0]  wr_ptr_reg;
    logic [PW-1:0]  rd_ptr_reg;
    logic [PW:0]    count_reg;
    logic           push_ok;
    logic           pop_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (PW+1)'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign count   = count_reg;
    // Head byte is visible the cycle after it is written.
    assign data    = mem[rd_ptr_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg] <= push_data;
    end
endmodule

// File: rtl/mem_io_bridge.sv
// Steers CPU byte accesses to block RAM or the I/O window, returning read data one cycle later.
// I/O: UART TX FIFO / RX pop on port 0, stop flag on port 4 write, cycle-counter snapshot on ports 4..7.
module mem_io_bridge
    import mem_io_bridge_pkg::*;
#(
    parameter int RAM_AW      = 17,
    parameter int TX_DEPTH    = 8,
    parameter int FULL_MARGIN = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    mem_io_bridge_if.slave    cpu,
    output logic              ram_en,
    output logic              ram_wr,
    output logic [RAM_AW-1:0] ram_a,
    output byte_t             ram_wdata,
    input  byte_t             ram_rdata,
    output byte_t             tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  byte_t             rx_data,
    input  logic              rx_valid,
    output logic              rx_pop,
    output logic              program_finished,
    output logic              tx_overflow
);
    localparam int CW = $clog2(TX_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_THR = CW'(TX_DEPTH - FULL_MARGIN);

    logic             io_sel;
    logic [2:0]       port;
    logic             tx_push;
    logic             tx_push_acc;
    byte_t            tx_push_data;
    logic             tx_pop;
    logic             tx_empty;
    logic             tx_full;
    logic [CW-1:0]    tx_count;
    logic [CW-1:0]    tx_count_next;
    byte_t            io_rd_byte;
    logic             unused_addr;

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] snap_reg;
    logic             io_sel_q_reg;
    logic             rd_pending_reg;
    byte_t            io_byte_reg;
    byte_t            din_hold_reg;
    logic             io_buffer_full_reg;
    logic             program_finished_reg;
    logic             tx_overflow_reg;

    assign io_sel      = (cpu.cpu_a[17:16] == IO_SEL_BITS);
    assign port        = cpu.cpu_a[2:0];
    assign unused_addr = ^cpu.cpu_a[CPU_AW-1:18];

    assign ram_en    = ~io_sel;
    assign ram_wr    = ~io_sel & cpu.cpu_wr;
    assign ram_a     = cpu.cpu_a[RAM_AW-1:0];
    assign ram_wdata = cpu.cpu_dout;

    // A 0x00 byte to the UART port is dropped; the stop port enqueues 0x00 as a terminator.
    assign tx_push      = io_sel & cpu.cpu_wr &
                          (((port == IO_PORT_UART) && (cpu.cpu_dout != '0)) || (port == IO_PORT_CLK));
    assign tx_push_data = (port == IO_PORT_CLK) ? '0 : cpu.cpu_dout;
    assign tx_valid     = ~tx_empty;
    assign tx_pop       = ~tx_empty & tx_ready;
    assign tx_push_acc  = tx_push & (~tx_full | tx_pop);
    assign rx_pop       = io_sel & ~cpu.cpu_wr & (port == IO_PORT_UART) & rx_valid;

    mem_io_bridge_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk_in),
        .rst_n     (rst_in),
        .push      (tx_push),
        .push_data (tx_push_data),
        .pop       (tx_pop),
        .data      (tx_data),
        .empty     (tx_empty),
        .full      (tx_full),
        .count     (tx_count)
    );

    always_comb begin
        tx_count_next = tx_count;
        if (tx_push_acc && !tx_pop)      tx_count_next = tx_count + 1'b1;
        else if (!tx_push_acc && tx_pop) tx_count_next = tx_count - 1'b1;
    end

    // Port 4 returns the live counter's low byte while it loads the snapshot; 5..7 read the snapshot.
    always_comb begin
        io_rd_byte = '0;
        if (port == IO_PORT_UART)     io_rd_byte = rx_valid ? rx_data : '0;
        else if (port == IO_PORT_CLK) io_rd_byte = cnt_reg[7:0];
        else if (port[2])             io_rd_byte = cnt_byte(snap_reg, port[1:0]);
    end

    // Write cycles return nothing, so the bus keeps showing the last read result.
    assign cpu.cpu_din        = rd_pending_reg ? (io_sel_q_reg ? io_byte_reg : ram_rdata) : din_hold_reg;
    assign cpu.io_buffer_full = io_buffer_full_reg;
    assign program_finished   = program_finished_reg;
    assign tx_overflow        = tx_overflow_reg;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt_reg              <= '0;
            snap_reg             <= '0;
            io_sel_q_reg         <= 1'b0;
            rd_pending_reg       <= 1'b0;
            io_byte_reg          <= '0;
            din_hold_reg         <= '0;
            io_buffer_full_reg   <= 1'b0;
            program_finished_reg <= 1'b0;
            tx_overflow_reg      <= 1'b0;
        end else begin
            cnt_reg            <= cnt_reg + 32'd1;
            io_sel_q_reg       <= io_sel;
            rd_pending_reg     <= ~cpu.cpu_wr;
            io_byte_reg        <= io_rd_byte;
            din_hold_reg       <= cpu.cpu_din;
            io_buffer_full_reg <= (tx_count_next >= FULL_THR);
            if (io_sel && !cpu.cpu_wr && port == IO_PORT_CLK) snap_reg <= cnt_reg;
            if (io_sel && cpu.cpu_wr && port == IO_PORT_CLK)  program_finished_reg <= 1'b1;
            if (tx_push && tx_full && !tx_pop)                tx_overflow_reg <= 1'b1;
        end
    end
endmodule
